// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel game-tick generator. Each channel emits a 1-cycle tick strobe
// every eff_period clk cycles, a level that toggles on each tick, and a wrapping tick counter.
// Ports: clk, rst (sync, active-high), mode (game-mode code, counts only when == GAME_MODE),
//        pause, period (CHANNELS*CTR_W, ch i at [i*CTR_W +: CTR_W]) -> tick, level, tick_cnt.
// Optional feature: define SNAKE_TICK_SPEEDUP_EN to shorten each channel's period every
// RAMP_TICKS ticks by RAMP_STEP cycles, floored at MIN_PERIOD.
module game_tick_gen #(
    parameter int         CHANNELS   = 2,
    parameter int         CTR_W      = 26,
    parameter int         RST_PERIOD = 37500000,
    parameter int         CNT_W      = 16,
    parameter int         RAMP_TICKS = 64,
    parameter int         RAMP_STEP  = 1000000,
    parameter int         MIN_PERIOD = 4000000,
    parameter logic [1:0] GAME_MODE  = 2'd1     // encoding of GAME in the game_mode enum
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      pause,
    input  logic [CHANNELS*CTR_W-1:0] period,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS*CNT_W-1:0] tick_cnt
);

    localparam logic [CTR_W-1:0] RST_P = CTR_W'(RST_PERIOD);

    logic in_game;
    assign in_game = (mode == GAME_MODE);

    // Periods below 2 would allow back-to-back ticks and a level with no low phase.
    function automatic logic [CTR_W-1:0] clamp2(input logic [CTR_W-1:0] p);
        return (p < CTR_W'(2)) ? CTR_W'(2) : p;
    endfunction

`ifndef SNAKE_TICK_SPEEDUP_EN
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = (RAMP_TICKS == 0) ^ (RAMP_STEP == 0) ^ (MIN_PERIOD == 0);
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CTR_W-1:0] ctr;
        logic [CTR_W-1:0] eff_period;
        logic [CTR_W-1:0] req;
        logic [CTR_W-1:0] reload;
        logic [CNT_W-1:0] cnt;
        logic             tck;
        logic             lvl;
        logic             at_end;

        assign req = clamp2(period[i*CTR_W +: CTR_W]);

        // ctr >= eff_period-1 evaluated one bit wider so a zero period cannot underflow.
        assign at_end = ({1'b0, ctr} + (CTR_W+1)'(1)) >= {1'b0, eff_period};

`ifdef SNAKE_TICK_SPEEDUP_EN
        localparam int RW = (RAMP_TICKS < 2) ? 1 : $clog2(RAMP_TICKS);
        localparam logic [CTR_W-1:0] MIN_P = CTR_W'(MIN_PERIOD);

        logic [RW-1:0]    ramp_ctr;
        logic [CTR_W-1:0] offset;
        logic [CTR_W-1:0] offset_next;
        logic [CTR_W:0]   offset_sum;
        logic [CTR_W-1:0] reduced;
        logic             ramp_hit;

        // The tick that completes a ramp step already reloads with the larger offset.
        always_comb begin
            ramp_hit    = (ramp_ctr == RW'(RAMP_TICKS - 1));
            offset_sum  = {1'b0, offset} + (CTR_W+1)'(RAMP_STEP);
            offset_next = offset;
            if (ramp_hit) begin
                offset_next = offset_sum[CTR_W] ? {CTR_W{1'b1}} : offset_sum[CTR_W-1:0];
            end
            reduced = (req > offset_next) ? (req - offset_next) : '0;
            reload  = (reduced < MIN_P) ? MIN_P : reduced;
        end

        always_ff @(posedge clk) begin
            if (rst || !in_game) begin
                ramp_ctr <= '0;
                offset   <= '0;
            end else if (!pause && at_end) begin
                ramp_ctr <= ramp_hit ? '0 : ramp_ctr + RW'(1);
                offset   <= offset_next;
            end
        end
`else
        assign reload = req;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                ctr        <= '0;
                eff_period <= RST_P;
                cnt        <= '0;
                tck        <= 1'b0;
                lvl        <= 1'b0;
            end else if (!in_game) begin
                ctr        <= '0;
                eff_period <= req;
                cnt        <= '0;
                tck        <= 1'b0;
            end else if (pause) begin
                tck        <= 1'b0;
            end else if (at_end) begin
                ctr        <= '0;
                eff_period <= reload;
                cnt        <= cnt + CNT_W'(1);
                tck        <= 1'b1;
                lvl        <= ~lvl;
            end else begin
                ctr        <= ctr + CTR_W'(1);
                tck        <= 1'b0;
            end
        end

        assign tick[i]                   = tck;
        assign level[i]                  = lvl;
        assign tick_cnt[i*CNT_W +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: directed bench for game_tick_gen with CHANNELS=2, CTR_W=8, RST_PERIOD=10,
// CNT_W=4. Inputs change and outputs are sampled 1 time unit after each rising edge; cycle i of
// a scenario is the i-th rising edge after mode became GAME.
module tb_game_tick_gen;

    localparam logic [1:0] MENU = 2'd0;
    localparam logic [1:0] GAME = 2'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        pause;
    logic [15:0] period;
    logic [1:0]  tick;
    logic [1:0]  level;
    logic [7:0]  tick_cnt;

    int checks = 0;
    int errors = 0;

    game_tick_gen #(
        .CHANNELS(2), .CTR_W(8), .RST_PERIOD(10), .CNT_W(4),
        .RAMP_TICKS(2), .RAMP_STEP(1), .MIN_PERIOD(3), .GAME_MODE(GAME)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .pause(pause), .period(period),
        .tick(tick), .level(level), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset in MENU, load the channel periods, then enter GAME; the next edge is cycle 1.
    task automatic enter_game(input logic [7:0] p0, input logic [7:0] p1);
        rst = 1'b1; mode = MENU; pause = 1'b0; period = {p1, p0};
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        mode = GAME;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = GAME; pause = 1'b0; period = {8'd6, 8'd4};
        repeat (3) step();
        checks++;
        if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick got %b exp 00", tick); end
        checks++;
        if (level !== 2'b00) begin errors++; $display("FAIL reset_level got %b exp 00", level); end
        checks++;
        if (tick_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", tick_cnt); end
    endtask

    // Leaves reset straight into GAME: first ticks come from RST_PERIOD, then ch0=4, ch1=6.
    task automatic test_multi_channel();
        logic [1:0] exp;
        rst = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step();
            exp[0] = (i >= 10) && ((i - 10) % 4 == 0);
            exp[1] = (i >= 10) && ((i - 10) % 6 == 0);
            checks++;
            if (tick !== exp) begin
                errors++; $display("FAIL multi_tick cyc %0d got %b exp %b", i, tick, exp);
            end
        end
        checks++;
        if (level !== 2'b10) begin errors++; $display("FAIL multi_level got %b exp 10", level); end
        checks++;
        if (tick_cnt !== 8'h34) begin errors++; $display("FAIL multi_cnt got %h exp 34", tick_cnt); end
    endtask

    // Period 0 clamps to 2; the 4-bit counter wraps after 15.
    task automatic test_min_period_wrap();
        logic       exp;
        logic [3:0] exp_cnt;
        enter_game(8'd0, 8'd200);
        checks++;
        if (tick_cnt !== 8'h00) begin errors++; $display("FAIL menu_cnt got %h exp 00", tick_cnt); end
        for (int i = 1; i <= 32; i++) begin
            step();
            exp = (i % 2 == 0);
            exp_cnt = 4'((i / 2) % 16);
            checks++;
            if (tick !== {1'b0, exp}) begin
                errors++; $display("FAIL clamp_tick cyc %0d got %b exp %b", i, tick, {1'b0, exp});
            end
            checks++;
            if (tick_cnt[3:0] !== exp_cnt) begin
                errors++; $display("FAIL wrap_cnt cyc %0d got %0d exp %0d", i, tick_cnt[3:0], exp_cnt);
            end
        end
    endtask

    // Pause over cycles 8..10 (ctr=2) pushes the second tick from 10 to 13.
    task automatic test_pause();
        logic       exp;
        logic [3:0] exp_cnt;
        enter_game(8'd5, 8'd200);
        for (int i = 1; i <= 14; i++) begin
            if (i == 8)  pause = 1'b1;
            if (i == 11) pause = 1'b0;
            step();
            exp = (i == 5) || (i == 13);
            exp_cnt = (i < 5) ? 4'd0 : (i < 13) ? 4'd1 : 4'd2;
            checks++;
            if (tick !== {1'b0, exp}) begin
                errors++; $display("FAIL pause_tick cyc %0d got %b exp %b", i, tick, {1'b0, exp});
            end
            checks++;
            if (tick_cnt[3:0] !== exp_cnt) begin
                errors++; $display("FAIL pause_cnt cyc %0d got %0d exp %0d", i, tick_cnt[3:0], exp_cnt);
            end
        end
    endtask

    // Period 5->9 written at ctr=1: ticks 5,10,19. MENU at ctr=3 clears count, holds level.
    task automatic test_period_change();
        logic exp;
        enter_game(8'd5, 8'd200);
        for (int i = 1; i <= 34; i++) begin
            if (i == 7)  period[7:0] = 8'd9;
            if (i == 23) mode = MENU;
            step();
            exp = (i == 5) || (i == 10) || (i == 19);
            checks++;
            if (tick !== {1'b0, exp}) begin
                errors++; $display("FAIL reload_tick cyc %0d got %b exp %b", i, tick, {1'b0, exp});
            end
            if (i >= 23) begin
                checks++;
                if (tick_cnt !== 8'h00) begin
                    errors++; $display("FAIL menu_clear cyc %0d got %h exp 00", i, tick_cnt);
                end
            end
        end
        checks++;
        if (level !== 2'b01) begin errors++; $display("FAIL menu_level got %b exp 01", level); end
    endtask

    // rst at ctr=3 clears everything; eff_period returns to RST_PERIOD on both channels.
    task automatic test_reset_mid();
        logic [1:0] exp;
        enter_game(8'd5, 8'd200);
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = (i == 5) ? 2'b01 : 2'b00;
            checks++;
            if (tick !== exp) begin
                errors++; $display("FAIL pre_rst_tick cyc %0d got %b exp %b", i, tick, exp);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (tick !== 2'b00) begin errors++; $display("FAIL rst_mid_tick got %b exp 00", tick); end
        checks++;
        if (level !== 2'b00) begin errors++; $display("FAIL rst_mid_level got %b exp 00", level); end
        checks++;
        if (tick_cnt !== 8'h00) begin errors++; $display("FAIL rst_mid_cnt got %h exp 00", tick_cnt); end
        for (int i = 1; i <= 11; i++) begin
            step();
            exp = (i == 10) ? 2'b11 : 2'b00;
            checks++;
            if (tick !== exp) begin
                errors++; $display("FAIL post_rst_tick cyc %0d got %b exp %b", i, tick, exp);
            end
        end
    endtask

`ifdef SNAKE_TICK_SPEEDUP_EN
    // Intervals 5,5,4,4,3,3,3 -> ticks at 5,10,14,18,21,24,27; MENU restores period 5.
    task automatic test_speedup();
        logic exp;
        enter_game(8'd5, 8'd200);
        for (int i = 1; i <= 28; i++) begin
            step();
            exp = (i == 5) || (i == 10) || (i == 14) || (i == 18) ||
                  (i == 21) || (i == 24) || (i == 27);
            checks++;
            if (tick !== {1'b0, exp}) begin
                errors++; $display("FAIL ramp_tick cyc %0d got %b exp %b", i, tick, {1'b0, exp});
            end
        end
        mode = MENU;
        repeat (2) step();
        mode = GAME;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp = (i == 5);
            checks++;
            if (tick !== {1'b0, exp}) begin
                errors++; $display("FAIL ramp_reset cyc %0d got %b exp %b", i, tick, {1'b0, exp});
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = MENU; pause = 1'b0; period = '0;
        test_reset();
        test_multi_channel();
        test_min_period_wrap();
        test_pause();
        test_period_change();
        test_reset_mid();
`ifdef SNAKE_TICK_SPEEDUP_EN
        test_speedup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
